// File: rtl/reg_file_pkg.sv
// Shared constants and types for the two-read/one-write register file.
package reg_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback-side bus of the register file: two read indices, one write port.
interface reg_file_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, write_enable,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, write_enable,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file_read_port.sv
// One combinational read port: r0 forced to zero, array mux, optional
// write-through forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_read_port #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic [ADDR_W-1:0]                rd_idx,
  input  logic [NUM_REGS-1:1][DATA_W-1:0]  regs,
`ifdef REG_FILE_BYPASS_EN
  input  logic                             byp_en,
  input  logic [ADDR_W-1:0]                wr_idx,
  input  logic [DATA_W-1:0]                wr_data,
`endif
  output logic [DATA_W-1:0]                rd_data
);

  always_comb begin
    rd_data = '0;
    if (rd_idx != ADDR_W'(reg_file_pkg::ZERO_REG)) begin
`ifdef REG_FILE_BYPASS_EN
      // byp_en already excludes reset and writes to r0
      if (byp_en && (rd_idx == wr_idx)) rd_data = wr_data;
      else                              rd_data = regs[rd_idx];
`else
      rd_data = regs[rd_idx];
`endif
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file top: storage for r1..r(N-1), write decode, async clear.
// Build option: REG_FILE_BYPASS_EN enables write-through forwarding on both read ports.
module reg_file #(
  parameter int DATA_W   = reg_file_pkg::DATA_W,
  parameter int ADDR_W   = reg_file_pkg::ADDR_W,
  parameter int NUM_REGS = reg_file_pkg::NUM_REGS
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  // r0 has no storage; it is synthesised as a constant in the read ports
  logic [NUM_REGS-1:1][DATA_W-1:0] regs;
  logic                            wr_go;

  assign wr_go = rst_n && bus.write_enable &&
                 (bus.write_reg != ADDR_W'(reg_file_pkg::ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     regs <= '0;
    else if (wr_go) regs[bus.write_reg] <= bus.write_data;
  end

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) u_rd1 (
    .rd_idx  (bus.read_reg1),
    .regs    (regs),
`ifdef REG_FILE_BYPASS_EN
    .byp_en  (wr_go),
    .wr_idx  (bus.write_reg),
    .wr_data (bus.write_data),
`endif
    .rd_data (bus.read_data1)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) u_rd2 (
    .rd_idx  (bus.read_reg2),
    .regs    (regs),
`ifdef REG_FILE_BYPASS_EN
    .byp_en  (wr_go),
    .wr_idx  (bus.write_reg),
    .wr_data (bus.write_data),
`endif
    .rd_data (bus.read_data2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read data computed
// from an array model; a monitor pops and compares mid-cycle.
module tb_reg_file;
  import reg_file_pkg::*;

  typedef struct {
    reg_word_t d1;
    reg_word_t d2;
    string     tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t      scb[$];
  reg_word_t model [NUM_REGS];
  logic      pend_vld;
  reg_idx_t  pend_idx;
  reg_word_t pend_data;
  int        n_checks = 0;
  int        n_fail   = 0;

  function automatic reg_word_t exp_read(reg_idx_t r, logic rst, logic we,
                                         reg_idx_t w, reg_word_t wd);
    if (r == 0 || !rst) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we && w == r) return wd;
`endif
    return model[r];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    pend_vld = 1'b0;
  endtask

  // Called at a rising edge: apply the write the DUT should have captured
  task automatic commit();
    if (pend_vld && rst_n) model[pend_idx] = pend_data;
    pend_vld = 1'b0;
  endtask

  task automatic drive(input string tag, input logic rst, input reg_idx_t r1,
                       input reg_idx_t r2, input reg_idx_t w,
                       input reg_word_t wd, input logic we);
    exp_t e;
    @(posedge clk);
    commit();
    #1;
    rst_n            = rst;
    bus.read_reg1    = r1;
    bus.read_reg2    = r2;
    bus.write_reg    = w;
    bus.write_data   = wd;
    bus.write_enable = we;
    if (!rst) clear_model();
    e.d1  = exp_read(r1, rst, we, w, wd);
    e.d2  = exp_read(r2, rst, we, w, wd);
    e.tag = tag;
    scb.push_back(e);
    pend_vld  = rst && we && (w != 0);
    pend_idx  = w;
    pend_data = wd;
  endtask

  // Reset dropped between edges while a write is presented; it stays low
  // across the next edge so that write must be lost.
  task automatic reset_pulse(input string tag, input reg_idx_t r);
    exp_t e;
    @(posedge clk);
    commit();
    #1;
    bus.read_reg1    = r;
    bus.read_reg2    = r;
    bus.write_reg    = r;
    bus.write_data   = $urandom;
    bus.write_enable = 1'b1;
    #1;
    rst_n = 1'b0;
    clear_model();
    e.d1  = '0;
    e.d2  = '0;
    e.tag = tag;
    scb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scb.size() > 0) begin
        e = scb.pop_front();
        n_checks++;
        if (bus.read_data1 !== e.d1) begin
          n_fail++;
          $display("FAIL %s read_data1: got %h expected %h", e.tag, bus.read_data1, e.d1);
        end
        n_checks++;
        if (bus.read_data2 !== e.d2) begin
          n_fail++;
          $display("FAIL %s read_data2: got %h expected %h", e.tag, bus.read_data2, e.d2);
        end
      end
    end
  end

  initial begin : stim
    reg_idx_t  r1, r2, w;
    reg_word_t wd;
    logic      we;
    int        guard;
    bus.read_reg1 = '0; bus.read_reg2 = '0; bus.write_reg = '0;
    bus.write_data = '0; bus.write_enable = 1'b0;
    clear_model();
    #1 rst_n = 1'b0;

    drive("rst_held_wr_blocked", 1'b0, 5'd2, 5'd31, 5'd2, 32'hCAFE_F00D, 1'b1);
    drive("rst_release_0_2",     1'b1, 5'd0, 5'd2,  5'd0, 32'h0, 1'b0);
    drive("rst_release_31",      1'b1, 5'd31, 5'd31, 5'd0, 32'h0, 1'b0);

    drive("wr_r2",    1'b1, 5'd2, 5'd3, 5'd2, 32'hFFFF_FFFF, 1'b1);
    drive("wr_r3",    1'b1, 5'd2, 5'd3, 5'd3, 32'h0000_000A, 1'b1);
    drive("rd_r2_r3", 1'b1, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0);

    for (int i = 0; i < 3; i++)
      drive("we_low_r2", 1'b1, 5'd2, 5'd2, 5'd2, 32'h3, 1'b0);
    drive("we_low_after", 1'b1, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0);

    drive("wr_r0",      1'b1, 5'd0, 5'd0, 5'd0, 32'hDEAD_BEEF, 1'b1);
    drive("rd_r0",      1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    drive("r0_no_side", 1'b1, 5'd2, 5'd3, 5'd0, 32'h0, 1'b0);

    drive("same_cyc_r5",  1'b1, 5'd5, 5'd5, 5'd5, 32'h1234_5678, 1'b1);
    drive("after_wr_r5",  1'b1, 5'd5, 5'd2, 5'd0, 32'h0, 1'b0);

    reset_pulse("async_rst_r2", 5'd2);
    drive("post_rst_r2_r5", 1'b1, 5'd2, 5'd5, 5'd0, 32'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_pulse("rand_rst", 5'($urandom_range(0, NUM_REGS-1)));
        continue;
      end
      w  = 5'($urandom_range(0, NUM_REGS-1));
      wd = $urandom;
      we = ($urandom_range(0, 99) < 70);
      r1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, NUM_REGS-1));
      r2 = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, NUM_REGS-1));
      drive("rand", 1'b1, r1, r2, w, wd, we);
    end

    guard = 0;
    while (scb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (scb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", scb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
